if_fetch_unit: RTL and testbench

Instruction-fetch stage that sits directly upstream of the IF/ID buffer. It owns the program counter and issues word fetches to a variable-latency instruction memory through a req/ack handshake. Fetched instructions are queued in a small prefetch FIFO and presented to IF/ID together with their PC and PC+4. A taken branch from EX/MEM redirects the PC, flushes the queue and discards any in-flight fetch.

---
 rtl/if_fetch_unit.sv | 135 +++++++++++++
 tb/tb_if_fetch_unit.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack memory port and
// queues instructions with their PC/PC+4 in a prefetch FIFO ahead of IF/ID.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        id_stall,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4
);

  localparam int unsigned      PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned      CNT_W    = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

  typedef enum logic {S_RUN, S_DROP} state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  state_e             state_q, state_d;
  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic [31:0]        addr_q, addr_d;
  logic               req_q, req_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  entry_t             fifo_q [FIFO_DEPTH];
  logic               valid_q, valid_d;
  entry_t             head_q, head_d;
  entry_t             push_entry;
  logic               ack_c, push_c, pop_c;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // An ack only counts against a live request; redirect kills both push and pop.
  assign ack_c  = req_q & imem_ack;
  assign push_c = (state_q == S_RUN) & ack_c & ~redirect;
  assign pop_c  = (cnt_q != '0) & ~id_stall & ~redirect;

  always_comb begin
    state_d          = state_q;
    fetch_pc_d       = fetch_pc_q;
    cnt_d            = cnt_q;
    wr_ptr_d         = wr_ptr_q;
    rd_ptr_d         = rd_ptr_q;
    push_entry.instr = imem_data;
    push_entry.pc    = fetch_pc_q;

    if (redirect) begin
      fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
      cnt_d      = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      state_d    = (req_q && !imem_ack) ? S_DROP : S_RUN;
    end else if (state_q == S_DROP) begin
      if (ack_c) state_d = S_RUN;
    end else begin
      if (push_c) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        wr_ptr_d   = ptr_inc(wr_ptr_q);
      end
      if (pop_c) rd_ptr_d = ptr_inc(rd_ptr_q);
      cnt_d = cnt_q + CNT_W'(push_c) - CNT_W'(pop_c);
    end

    // The stale request keeps its address until it is acked.
    req_d   = (state_d == S_DROP) || (cnt_d < DEPTH_C);
    addr_d  = (state_d == S_DROP) ? addr_q : fetch_pc_d;
    valid_d = (cnt_d != '0);

    // Next head is the entry being pushed when nothing older survives the pop.
    if (!valid_d) begin
      head_d = '0;
    end else if (push_c && ((cnt_q - CNT_W'(pop_c)) == '0)) begin
      head_d = push_entry;
    end else begin
      head_d = fifo_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_RUN;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      req_q      <= 1'b0;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      valid_q    <= 1'b0;
      head_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      req_q      <= req_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      valid_q    <= valid_d;
      head_q     <= head_d;
    end
  end

  // Storage needs no reset: entries are only read once counted valid.
  always_ff @(posedge clk) begin
    if (push_c) fifo_q[wr_ptr_q] <= push_entry;
  end

  assert property (@(posedge clk) disable iff (!rst_n) !(push_c && (cnt_q == DEPTH_C)));

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign if_valid  = valid_q;
  assign if_instr  = head_q.instr;
  assign if_pc     = head_q.pc;
  assign if_pc4    = valid_q ? head_q.pc + 32'd4 : 32'd0;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: scoreboard of expected PCs checked at each
// IF/ID handshake, plus cycle-exact checks on the memory port.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_data;
  logic        redirect, id_stall;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_instr, if_pc, if_pc4;

  logic        req1, ack1;
  logic [31:0] addr1, data1;
  logic        redirect1 = 1'b0;
  logic        stall1 = 1'b0;
  logic [31:0] rpc1 = 32'd0;
  logic        valid1;
  logic [31:0] instr1, pc1, pc41;

  int unsigned lat;
  int unsigned wait_cnt;
  logic        stale_ack;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] sb [$];
  logic [31:0] exp_pc;
  int          n;

  always #5 clk = ~clk;

  if_fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .redirect(redirect), .redirect_pc(redirect_pc), .id_stall(id_stall),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_pc4(if_pc4)
  );

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .rst_n(rst_n),
    .imem_req(req1), .imem_addr(addr1), .imem_ack(ack1), .imem_data(data1),
    .redirect(redirect1), .redirect_pc(rpc1), .id_stall(stall1),
    .if_valid(valid1), .if_instr(instr1), .if_pc(pc1), .if_pc4(pc41)
  );

  // Memory model: mem[a] = a | 0xA000_0000, ack after 'lat' waiting cycles.
  assign imem_ack  = (imem_req && (wait_cnt >= lat)) || stale_ack;
  assign imem_data = imem_addr | 32'hA000_0000;
  assign ack1      = req1;
  assign data1     = addr1 | 32'hA000_0000;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     wait_cnt <= 0;
    else if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
    else                            wait_cnt <= 0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while (sb.size() != 0 && k < budget) begin
      cyc();
      k++;
    end
    chk("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  task automatic wait_full(input int budget);
    int k;
    k = 0;
    while (imem_req && k < budget) begin
      cyc();
      k++;
    end
    chk1("full_req_low", imem_req, 1'b0);
  endtask

  // Every accepted head must match the next expected PC.
  always @(negedge clk) begin
    if (rst_n && if_valid && !id_stall && !redirect) begin
      chk1("sb_has_entry", sb.size() != 0, 1'b1);
      if (sb.size() != 0) begin
        exp_pc = sb.pop_front();
        chk("if_pc", if_pc, exp_pc);
        chk("if_pc4", if_pc4, exp_pc + 32'd4);
        chk("if_instr", if_instr, exp_pc | 32'hA000_0000);
      end
    end
  end

  initial begin
    rst_n = 1'b0; id_stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
    lat = 0; stale_ack = 1'b0;
    repeat (3) cyc();
    chk1("rst_req", imem_req, 1'b0);
    chk("rst_addr", imem_addr, 32'd0);
    chk1("rst_valid", if_valid, 1'b0);
    chk("rst_instr", if_instr, 32'd0);
    chk("rst_pc", if_pc, 32'd0);
    chk("rst_pc4", if_pc4, 32'd0);
    chk("rst_addr_wrapdut", addr1, 32'hFFFF_FFF8);

    // Zero-wait streaming from reset
    rst_n = 1'b1;
    sb.push_back(32'h0); sb.push_back(32'h4); sb.push_back(32'h8);
    cyc();
    chk1("c1_req", imem_req, 1'b1);
    chk("c1_addr", imem_addr, 32'h0);
    chk1("c1_valid", if_valid, 1'b0);
    cyc();
    chk("c2_addr", imem_addr, 32'h4);
    chk1("c2_valid", if_valid, 1'b1);
    chk("wrap_pc0", pc1, 32'hFFFF_FFF8);
    chk("wrap_pc4_0", pc41, 32'hFFFF_FFFC);
    chk("wrap_instr0", instr1, 32'hFFFF_FFF8);
    cyc();
    chk("c3_addr", imem_addr, 32'h8);
    chk("wrap_pc1", pc1, 32'hFFFF_FFFC);
    chk("wrap_pc4_1", pc41, 32'h0);
    cyc();
    chk("c4_addr", imem_addr, 32'hC);
    chk("wrap_pc2", pc1, 32'h0);
    chk("wrap_pc4_2", pc41, 32'h4);
    cyc();

    // Stall: FIFO fills to depth, request drops, head holds
    id_stall = 1'b1;
    chk("stream_consumed", 32'(sb.size()), 32'd0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk1("stall_req", imem_req, 1'b0);
      chk1("stall_valid", if_valid, 1'b1);
      chk("stall_head", if_pc, 32'hC);
    end
    cyc();
    id_stall = 1'b0;
    sb.push_back(32'hC); sb.push_back(32'h10); sb.push_back(32'h14); sb.push_back(32'h18);
    drain(20);
    id_stall = 1'b1;
    wait_full(10);

    // Redirect with an outstanding 3-cycle request -> stale data dropped
    lat = 3; redirect = 1'b1; redirect_pc = 32'h0; id_stall = 1'b0;
    sb.push_back(32'h0); sb.push_back(32'h4);
    cyc();
    redirect = 1'b0;
    chk1("flush_valid", if_valid, 1'b0);
    chk1("flush_req", imem_req, 1'b1);
    chk("flush_addr", imem_addr, 32'h0);
    n = 0;
    while (!(imem_req && imem_addr == 32'h8) && n < 30) begin
      cyc();
      n++;
    end
    chk("req8_seen", imem_addr, 32'h8);
    cyc();
    chk("sb_before_redirect", 32'(sb.size()), 32'd0);
    redirect = 1'b1; redirect_pc = 32'h100;
    cyc();
    redirect = 1'b0;
    sb.push_back(32'h100); sb.push_back(32'h104);
    chk1("drop_req", imem_req, 1'b1);
    chk("drop_addr", imem_addr, 32'h8);
    chk1("drop_valid", if_valid, 1'b0);
    cyc();
    chk("drop_addr_hold", imem_addr, 32'h8);
    cyc();
    chk("redir_addr", imem_addr, 32'h100);
    chk1("redir_valid", if_valid, 1'b0);
    drain(40);
    id_stall = 1'b1; lat = 0;

    // Redirect coinciding with an ack while one entry is queued and stalled
    n = 0;
    while (!(if_valid && imem_req && imem_ack) && n < 20) begin
      cyc();
      n++;
    end
    chk1("ack_with_entry", if_valid && imem_req && imem_ack, 1'b1);
    redirect = 1'b1; redirect_pc = 32'h203;
    cyc();
    redirect = 1'b0;
    chk1("same_ack_valid", if_valid, 1'b0);
    chk1("same_ack_req", imem_req, 1'b1);
    chk("same_ack_addr", imem_addr, 32'h200);
    sb.push_back(32'h200); sb.push_back(32'h204);
    id_stall = 1'b0;
    drain(20);
    id_stall = 1'b1;
    wait_full(10);

    // Reset in the middle of a slow request, then a stale ack while idle
    lat = 3; redirect = 1'b1; redirect_pc = 32'h300;
    cyc();
    redirect = 1'b0;
    chk("pre_rst_addr", imem_addr, 32'h300);
    chk1("pre_rst_req", imem_req, 1'b1);
    cyc();
    rst_n = 1'b0;
    #1;
    chk1("mid_rst_req", imem_req, 1'b0);
    chk("mid_rst_addr", imem_addr, 32'h0);
    chk1("mid_rst_valid", if_valid, 1'b0);
    chk("mid_rst_instr", if_instr, 32'h0);
    chk("mid_rst_pc", if_pc, 32'h0);
    chk("mid_rst_pc4", if_pc4, 32'h0);
    cyc();
    rst_n = 1'b1; stale_ack = 1'b1; id_stall = 1'b0;
    sb.push_back(32'h0); sb.push_back(32'h4);
    cyc();
    stale_ack = 1'b0;
    chk1("restart_req", imem_req, 1'b1);
    chk("restart_addr", imem_addr, 32'h0);
    chk1("stale_ack_ignored", if_valid, 1'b0);
    drain(40);
    id_stall = 1'b1;
    repeat (2) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
